// File: rtl/bcd_to_bi_seq.sv
// Sequential packed-BCD to binary converter: one digit per clock, MS digit first,
// with a valid/ready handshake on both the request and the result side.
module bcd_to_bi_seq #(
   parameter int NDIGITS = 3,
   parameter int BIN_W   = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NDIGITS-1:0]   bcd_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [BIN_W-1:0]       bin_out,
   output logic                   err
);

   localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic digit_bad(input logic [3:0] d);
      return (d > 4'd9);
   endfunction

   state_t                 state_r;
   state_t                 state_nx_s;
   logic [4*NDIGITS-1:0]   shift_r;
   logic [BIN_W-1:0]       acc_r;
   logic                   err_acc_r;
   logic [CNT_W-1:0]       cnt_r;
   logic                   in_ready_r;
   logic                   out_valid_r;
   logic [BIN_W-1:0]       bin_out_r;
   logic                   err_out_r;

   logic [3:0]             digit_s;
   logic [BIN_W-1:0]       acc_nx_s;
   logic                   err_nx_s;

   // Digit datapath: acc*10 + d; the x10 product is taken modulo 2**BIN_W directly,
   // which equals truncating the wider product.
   always_comb begin
      digit_s  = shift_r[4*NDIGITS-1 -: 4];
      acc_nx_s = (acc_r << 3'd3) + (acc_r << 3'd1) + BIN_W'(digit_s);
      err_nx_s = err_acc_r | digit_bad(digit_s);
   end

   // Next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               state_nx_s = CONV;
            end else begin
               state_nx_s = IDLE;
            end
         end
         CONV: begin
            if (cnt_r == {CNT_W{1'b0}}) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = CONV;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = DONE;
            end
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // State, datapath and registered handshake/result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         shift_r     <= '0;
         acc_r       <= '0;
         err_acc_r   <= 1'b0;
         cnt_r       <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         bin_out_r   <= '0;
         err_out_r   <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         in_ready_r  <= (state_nx_s == IDLE);
         out_valid_r <= (state_nx_s == DONE);
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  shift_r   <= bcd_in;
                  acc_r     <= '0;
                  err_acc_r <= 1'b0;
                  cnt_r     <= CNT_W'(NDIGITS - 1);
               end
            end
            CONV: begin
               acc_r     <= acc_nx_s;
               err_acc_r <= err_nx_s;
               shift_r   <= shift_r << 3'd4;
               cnt_r     <= cnt_r - CNT_W'(1);
               // Result is latched on the last digit so DONE presents it stably.
               if (cnt_r == {CNT_W{1'b0}}) begin
                  bin_out_r <= err_nx_s ? {BIN_W{1'b0}} : acc_nx_s;
                  err_out_r <= err_nx_s;
               end
            end
            DONE: begin
               bin_out_r <= bin_out_r;
            end
            default: begin
               bin_out_r <= '0;
               err_out_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign bin_out   = bin_out_r;
   assign err       = err_out_r;

endmodule

// File: tb/tb_bcd_to_bi_seq.sv
// Scoreboard bench for bcd_to_bi_seq: driver pushes expected results, a negedge
// monitor pops and compares on every output handshake.
module tb_bcd_to_bi_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] bcd_in = 12'h000;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [9:0]  bin_out;
   logic        err;

   int          checks = 0;
   int          errors = 0;
   logic [10:0] exp_q[$];
   logic [10:0] mon_exp;

   bcd_to_bi_seq #(.NDIGITS(3), .BIN_W(10)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .bcd_in(bcd_in), .out_valid(out_valid), .out_ready(out_ready),
      .bin_out(bin_out), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: compare the presented result on each cycle where a transfer will happen.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected result", 32'(out_valid), 32'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("result bin_out", 32'(bin_out), 32'(mon_exp[9:0]));
            chk("result err", 32'(err), 32'(mon_exp[10]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [11:0] bcd, input logic [9:0] eb, input logic ee, input bit push);
      int n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) chk("in_ready timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      bcd_in   = bcd;
      if (push) exp_q.push_back({ee, eb});
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      chk("drain timeout", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_latency(input string name);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk(name, 32'(out_valid), (k == 3) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      int n;
      tick();
      tick();
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset bin_out", 32'(bin_out), 32'd0);
      chk("reset err", 32'(err), 32'd0);
      rst = 1'b0;
      tick();

      // T1: 999 with latency and in_ready return
      out_ready = 1'b1;
      send(12'h999, 10'd999, 1'b0, 1'b1);
      check_latency("t1 latency");
      chk("t1 in_ready busy", 32'(in_ready), 32'd0);
      tick();
      chk("t1 in_ready back", 32'(in_ready), 32'd1);
      chk("t1 queue empty", 32'(exp_q.size()), 32'd0);

      // T2
      send(12'h000, 10'd0, 1'b0, 1'b1);
      drain();
      send(12'h256, 10'd256, 1'b0, 1'b1);
      drain();
      send(12'h040, 10'd40, 1'b0, 1'b1);
      drain();

      // T3: invalid middle nibble, then invalid last nibble
      send(12'h1A5, 10'd0, 1'b1, 1'b1);
      check_latency("t3 latency");
      drain();
      send(12'h12F, 10'd0, 1'b1, 1'b1);
      drain();

      // T4: output back-pressure
      out_ready = 1'b0;
      send(12'h075, 10'd75, 1'b0, 1'b1);
      check_latency("t4 latency");
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("t4 hold out_valid", 32'(out_valid), 32'd1);
         chk("t4 hold bin_out", 32'(bin_out), 32'd75);
         chk("t4 hold err", 32'(err), 32'd0);
         chk("t4 hold in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      chk("t4 in_ready after", 32'(in_ready), 32'd1);
      chk("t4 out_valid after", 32'(out_valid), 32'd0);
      chk("t4 queue empty", 32'(exp_q.size()), 32'd0);

      // T5: reset in 2nd CONV cycle abandons the request
      send(12'h512, 10'd512, 1'b0, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5 in_ready", 32'(in_ready), 32'd1);
      chk("t5 out_valid", 32'(out_valid), 32'd0);
      chk("t5 bin_out", 32'(bin_out), 32'd0);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("t5 no output", 32'(out_valid), 32'd0);
      end
      send(12'h768, 10'd768, 1'b0, 1'b1);
      drain();

      // T6: bcd_in change and in_valid during CONV
      send(12'h345, 10'd345, 1'b0, 1'b1);
      in_valid = 1'b1;
      bcd_in   = 12'h987;
      exp_q.push_back({1'b0, 10'd987});
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      chk("t6 second accept delay", 32'(n), 32'd4);
      tick();
      in_valid = 1'b0;
      bcd_in   = 12'h000;
      drain();

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1);
   end

endmodule
